// File: rtl/all_pkgs.sv
// Shared types and constants for the RV32I/RV64I decode stage.
package all_pkgs;

    localparam int WIDTH    = 32;
    localparam int MAX_XLEN = 64;
    localparam int MAX_PC_W = 64;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_type_e;

    // Bit 0 = main entry valid, bit 1 = skid entry valid.
    typedef enum logic [1:0] {
        SKID_EMPTY = 2'b00,
        SKID_ONE   = 2'b01,
        SKID_FULL  = 2'b11
    } skid_state_e;

    // Storage is sized for the widest configuration; narrower builds
    // zero-extend on capture and truncate on output.
    typedef struct packed {
        logic [MAX_PC_W-1:0] pc;
        logic [6:0]          opcode;
        logic [4:0]          rd;
        logic [2:0]          funct3;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [6:0]          funct7;
        logic [MAX_XLEN-1:0] imm;
        imm_type_e           imm_type;
        logic                illegal;
    } dec_bundle_t;

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate generator and base-ISA legality check.
module imm_gen
    import all_pkgs::*;
#(
    parameter int XLEN = 32
) (
    input  logic [WIDTH-1:0] instr,
    output logic [XLEN-1:0]  imm,
    output imm_type_e        imm_type,
    output logic             illegal
);

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [6:0]  shamt_hi;
    logic [31:0] imm32;
    imm_type_e   fmt;
    logic        bad;

    assign opc = instr[6:0];
    assign f3  = instr[14:12];
    assign f7  = instr[31:25];

    // Classify the opcode into an immediate format and flag illegal encodings.
    always_comb begin
        fmt      = IMM_NONE;
        bad      = 1'b0;
        shamt_hi = f7;
        // RV64 shifts use instr[25] as shamt[5].
        if (XLEN == 64) shamt_hi[0] = 1'b0;
        case (opc)
            OPC_LUI, OPC_AUIPC: fmt = IMM_U;
            OPC_JAL:            fmt = IMM_J;
            OPC_JALR: begin
                fmt = IMM_I;
                bad = (f3 != 3'b000);
            end
            OPC_BRANCH: begin
                fmt = IMM_B;
                bad = (f3 == 3'b010) || (f3 == 3'b011);
            end
            OPC_LOAD: begin
                fmt = IMM_I;
                case (f3)
                    3'b011, 3'b110: bad = (XLEN != 64);
                    3'b111:         bad = 1'b1;
                    default:        bad = 1'b0;
                endcase
            end
            OPC_STORE: begin
                fmt = IMM_S;
                bad = f3[2] || ((f3 == 3'b011) && (XLEN != 64));
            end
            OPC_OP_IMM: begin
                fmt = IMM_I;
                if (f3 == 3'b001)
                    bad = (shamt_hi != 7'b0000000);
                else if (f3 == 3'b101)
                    bad = (shamt_hi != 7'b0000000) && (shamt_hi != 7'b0100000);
            end
            OPC_OP: begin
                fmt = IMM_NONE;
                bad = !((f7 == 7'b0000000) ||
                        ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101))));
            end
            OPC_MISC_MEM, OPC_SYSTEM: fmt = IMM_I;
            default: bad = 1'b1;
        endcase
        if (instr[1:0] != 2'b11) bad = 1'b1;
    end

    // Assemble the 32-bit immediate for the selected format.
    always_comb begin
        case (fmt)
            IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                              instr[11:8], 1'b0};
            IMM_U:   imm32 = {instr[31:12], 12'b0};
            IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                              instr[30:21], 1'b0};
            default: imm32 = 32'b0;
        endcase
    end

    assign imm      = bad ? '0 : XLEN'($signed(imm32));
    assign imm_type = bad ? IMM_NONE : fmt;
    assign illegal  = bad;

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I/RV64I decode stage with a two-entry skid buffer.
//
//   state      | meaning
//   -----------+-------------------------------------------------
//   SKID_EMPTY | nothing held, in_ready = 1
//   SKID_ONE   | main holds a bundle, skid free, in_ready = 1
//   SKID_FULL  | main and skid both hold bundles, in_ready = 0
module decode_stage
    import all_pkgs::*;
#(
    parameter int XLEN = 32,
    parameter int PC_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_instr,
    input  logic [PC_W-1:0]  in_pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PC_W-1:0]  out_pc,
    output logic [6:0]       opcode,
    output logic [4:0]       rd,
    output logic [2:0]       funct3,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [6:0]       funct7,
    output logic [XLEN-1:0]  imm,
    output imm_type_e        imm_type,
    output logic             illegal
);

    dec_bundle_t     dec_in;
    dec_bundle_t     main_q;
    dec_bundle_t     skid_q;
    logic [XLEN-1:0] dec_imm;
    imm_type_e       dec_imm_type;
    logic            dec_illegal;

    skid_state_e     state_q;
    skid_state_e     state_n;
    logic            in_ready_q;
    logic            main_valid;
    logic            accept;
    logic            drain;
    logic            load_main_in;
    logic            load_main_skid;
    logic            load_skid;

    imm_gen #(
        .XLEN (XLEN)
    ) u_imm_gen (
        .instr    (in_instr),
        .imm      (dec_imm),
        .imm_type (dec_imm_type),
        .illegal  (dec_illegal)
    );

    // Pack the decoded fields of the incoming word into a bundle.
    always_comb begin
        dec_in          = '0;
        dec_in.pc       = MAX_PC_W'(in_pc);
        dec_in.opcode   = in_instr[6:0];
        dec_in.rd       = in_instr[11:7];
        dec_in.funct3   = in_instr[14:12];
        dec_in.rs1      = in_instr[19:15];
        dec_in.rs2      = in_instr[24:20];
        dec_in.funct7   = in_instr[31:25];
        dec_in.imm      = MAX_XLEN'(dec_imm);
        dec_in.imm_type = dec_imm_type;
        dec_in.illegal  = dec_illegal;
    end

    assign main_valid = state_q[0];
    assign accept     = in_valid && in_ready_q;
    assign drain      = main_valid && out_ready;

    // Skid state register; in_ready is registered from the next state so
    // out_ready never reaches it combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= SKID_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_n;
            in_ready_q <= (state_n != SKID_FULL);
        end
    end

    // Next-state and entry-load decisions; flush overrides everything.
    always_comb begin
        state_n        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_q)
            SKID_EMPTY: begin
                if (accept) begin
                    state_n      = SKID_ONE;
                    load_main_in = 1'b1;
                end
            end
            SKID_ONE: begin
                if (accept && drain) begin
                    load_main_in = 1'b1;
                end else if (accept) begin
                    state_n   = SKID_FULL;
                    load_skid = 1'b1;
                end else if (drain) begin
                    state_n = SKID_EMPTY;
                end
            end
            SKID_FULL: begin
                if (drain) begin
                    state_n        = SKID_ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: state_n = SKID_EMPTY;
        endcase
        if (flush) begin
            state_n        = SKID_EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    // Bundle storage: main feeds the outputs, skid absorbs one stalled word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_in)
                main_q <= dec_in;
            else if (load_main_skid)
                main_q <= skid_q;
            if (load_skid)
                skid_q <= dec_in;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_valid;
    assign out_pc    = main_q.pc[PC_W-1:0];
    assign opcode    = main_q.opcode;
    assign rd        = main_q.rd;
    assign funct3    = main_q.funct3;
    assign rs1       = main_q.rs1;
    assign rs2       = main_q.rs2;
    assign funct7    = main_q.funct7;
    assign imm       = main_q.imm[XLEN-1:0];
    assign imm_type  = main_q.imm_type;
    assign illegal   = main_q.illegal;

    // Upper storage bits are always zero in narrow configurations.
    if (PC_W < MAX_PC_W) begin : g_pc_pad
        logic unused_pc_hi;
        assign unused_pc_hi = ^main_q.pc[MAX_PC_W-1:PC_W];
    end
    if (XLEN < MAX_XLEN) begin : g_imm_pad
        logic unused_imm_hi;
        assign unused_imm_hi = ^main_q.imm[MAX_XLEN-1:XLEN];
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage (XLEN=32 and XLEN=64 instances).
module tb_decode_stage;
    import all_pkgs::*;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_instr;
    logic [31:0]      in_pc;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_pc;
    logic [6:0]       opcode;
    logic [4:0]       rd;
    logic [2:0]       funct3;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [6:0]       funct7;
    logic [31:0]      imm;
    imm_type_e        imm_type;
    logic             illegal;

    logic             unused64_in_ready;
    logic             unused64_out_valid;
    logic [31:0]      unused64_out_pc;
    logic [6:0]       unused64_opcode;
    logic [4:0]       unused64_rd;
    logic [2:0]       unused64_funct3;
    logic [4:0]       unused64_rs1;
    logic [4:0]       unused64_rs2;
    logic [6:0]       unused64_funct7;
    logic [63:0]      d64_imm;
    imm_type_e        unused64_imm_type;
    logic             unused64_illegal;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .PC_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2),
        .funct7(funct7), .imm(imm), .imm_type(imm_type), .illegal(illegal)
    );

    decode_stage #(.XLEN(64), .PC_W(32)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(unused64_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .out_valid(unused64_out_valid), .out_ready(out_ready), .out_pc(unused64_out_pc),
        .opcode(unused64_opcode), .rd(unused64_rd), .funct3(unused64_funct3),
        .rs1(unused64_rs1), .rs2(unused64_rs2), .funct7(unused64_funct7),
        .imm(d64_imm), .imm_type(unused64_imm_type), .illegal(unused64_illegal)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic put(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] ill_word [4];
        logic        ill_exp  [4];
        logic [31:0] words    [5];
        int          tx;
        int          rx;
        bit          fire;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (2) step();

        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_imm",       64'(imm),       64'd0);
        chk("rst_imm_type",  64'(imm_type),  64'(IMM_NONE));
        chk("rst_illegal",   64'(illegal),   64'd0);
        chk("rst_out_pc",    64'(out_pc),    64'd0);
        chk("rst_rd",        64'(rd),        64'd0);
        rst_n = 1'b1;
        step();

        // addi x1,x2,-1
        put(32'hFFF10093, 32'h100);
        step();
        chk("addi_valid",    64'(out_valid), 64'd1);
        chk("addi_pc",       64'(out_pc),    64'h100);
        chk("addi_opcode",   64'(opcode),    64'h13);
        chk("addi_rd",       64'(rd),        64'd1);
        chk("addi_rs1",      64'(rs1),       64'd2);
        chk("addi_imm",      64'(imm),       64'hFFFF_FFFF);
        chk("addi_type",     64'(imm_type),  64'(IMM_I));
        chk("addi_illegal",  64'(illegal),   64'd0);
        chk("addi_imm64",    d64_imm,        64'hFFFF_FFFF_FFFF_FFFF);

        // sw x5,8(x6) then beq x0,x0,-4 back to back
        put(32'h00532423, 32'h104);
        step();
        chk("sw_imm",    64'(imm),      64'h8);
        chk("sw_type",   64'(imm_type), 64'(IMM_S));
        chk("sw_rs1",    64'(rs1),      64'd6);
        chk("sw_rs2",    64'(rs2),      64'd5);
        chk("sw_funct3", 64'(funct3),   64'd2);
        put(32'hFE000EE3, 32'h108);
        step();
        chk("beq_valid", 64'(out_valid), 64'd1);
        chk("beq_pc",    64'(out_pc),    64'h108);
        chk("beq_imm",   64'(imm),       64'hFFFF_FFFC);
        chk("beq_type",  64'(imm_type),  64'(IMM_B));

        // jal x1,2048 then lui x5,0x12345
        put(32'h001000EF, 32'h10C);
        step();
        chk("jal_imm",  64'(imm),      64'h800);
        chk("jal_type", 64'(imm_type), 64'(IMM_J));
        chk("jal_rd",   64'(rd),       64'd1);
        put(32'h123452B7, 32'h110);
        step();
        chk("lui_imm",  64'(imm),      64'h1234_5000);
        chk("lui_type", 64'(imm_type), 64'(IMM_U));
        chk("lui_rd",   64'(rd),       64'd5);

        // all-zero word is illegal; lw with low bits 11 is legal
        put(32'h00000000, 32'h114);
        step();
        chk("zero_illegal", 64'(illegal),  64'd1);
        chk("zero_imm",     64'(imm),      64'd0);
        chk("zero_type",    64'(imm_type), 64'(IMM_NONE));
        put(32'h0000A003, 32'h118);
        step();
        chk("lw_illegal", 64'(illegal),  64'd0);
        chk("lw_type",    64'(imm_type), 64'(IMM_I));
        chk("lw_funct3",  64'(funct3),   64'd2);

        // OP funct7=0100000 with sll, srai x1,x1,3, slli with bad upper, jalr funct3=001
        ill_word[0] = 32'h40001033; ill_exp[0] = 1'b1;
        ill_word[1] = 32'h4030D093; ill_exp[1] = 1'b0;
        ill_word[2] = 32'h40309093; ill_exp[2] = 1'b1;
        ill_word[3] = 32'h00001067; ill_exp[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            put(ill_word[i], 32'h120 + 32'(4 * i));
            step();
            chk($sformatf("legality_%0d", i), 64'(illegal), 64'(ill_exp[i]));
            if (i == 0) chk("op_funct7", 64'(funct7), 64'h20);
            if (i == 1) chk("srai_imm", 64'(imm), 64'h403);
        end
        in_valid = 1'b0;
        step();
        step();
        chk("drained_valid", 64'(out_valid), 64'd0);

        // five-word stream with out_ready held low for three cycles
        for (int k = 0; k < 5; k++)
            words[k] = {12'(k + 1), 5'd0, 3'b000, 5'(k + 1), 7'b0010011};
        tx   = 0;
        rx   = 0;
        fire = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (fire) tx++;
            out_ready = (cyc >= 3);
            if (out_valid && out_ready && rx < 5) begin
                chk($sformatf("stream_pc_%0d", rx), 64'(out_pc), 64'(32'h400 + 32'(4 * rx)));
                chk($sformatf("stream_rd_%0d", rx), 64'(rd),     64'(rx + 1));
                rx++;
            end
            if (cyc == 1) begin
                chk("stall_in_ready_1", 64'(in_ready), 64'd1);
                chk("stall_hold_pc_1",  64'(out_pc),   64'h400);
            end
            if (cyc == 2) begin
                chk("stall_in_ready_2", 64'(in_ready), 64'd0);
                chk("stall_hold_pc_2",  64'(out_pc),   64'h400);
            end
            if (tx < 5) begin
                put(words[tx], 32'h400 + 32'(4 * tx));
            end else begin
                in_valid = 1'b0;
            end
            fire = in_valid && in_ready;
            step();
        end
        chk("stream_count", 64'(rx), 64'd5);

        // flush while FULL
        out_ready = 1'b0;
        put(32'h00100093, 32'h200);
        step();
        put(32'h00200113, 32'h204);
        step();
        chk("full_in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        flush    = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_full_valid", 64'(out_valid), 64'd0);
        chk("flush_full_ready", 64'(in_ready),  64'd1);
        out_ready = 1'b1;
        put(32'h00300193, 32'h208);
        step();
        chk("post_flush_valid", 64'(out_valid), 64'd1);
        chk("post_flush_pc",    64'(out_pc),    64'h208);
        chk("post_flush_rd",    64'(rd),        64'd3);

        // an acceptance in the flush cycle is discarded
        put(32'h00400213, 32'h20C);
        flush = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_accept_valid", 64'(out_valid), 64'd0);
        step();
        chk("flush_accept_gone",  64'(out_valid), 64'd0);

        // asynchronous reset mid-stream
        out_ready = 1'b0;
        put(32'h00100093, 32'h300);
        step();
        put(32'h00200113, 32'h304);
        step();
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        chk("async_rst_valid", 64'(out_valid), 64'd0);
        chk("async_rst_ready", 64'(in_ready),  64'd1);
        rst_n = 1'b1;
        step();
        chk("rst_release_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        put(32'h00300193, 32'h308);
        step();
        chk("post_rst_valid", 64'(out_valid), 64'd1);
        chk("post_rst_pc",    64'(out_pc),    64'h308);
        in_valid = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
